// File: rtl/hins_rst_seq.sv
// Reset sequencer for the HINS CPU clock domain: synchronises PLL lock, waits for a
// stable lock, releases N_DOM resets in index order and handles lock loss and soft resets.
module hins_rst_seq #(
  parameter int N_DOM           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int LOCK_STABLE_CYC = 1024,
  parameter int STAGE_GAP_CYC   = 16,
  parameter int SW_PULSE_CYC    = 8,
  parameter int CNT_W           = 16
) (
  input  logic             pll_clk_cpu_int,
  input  logic             RST_EXT_N,
  input  logic             pll_locked,
  input  logic             sw_rst_req,
  input  logic [N_DOM-1:0] sw_rst_mask,
  output logic [N_DOM-1:0] rst_n_out,
  output logic             all_released,
  output logic [2:0]       seq_state,
  output logic [7:0]       lock_loss_cnt
);

  localparam logic [2:0] S_HOLD    = 3'd0;
  localparam logic [2:0] S_STABLE  = 3'd1;
  localparam logic [2:0] S_RELEASE = 3'd2;
  localparam logic [2:0] S_RUN     = 3'd3;
  localparam logic [2:0] S_SWRST   = 3'd4;

  localparam int IDX_W = $clog2(N_DOM + 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(STAGE_GAP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST  = CNT_W'(SW_PULSE_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_DONE    = IDX_W'(N_DOM);

  logic [SYNC_STAGES-1:0] sync;
  logic                   lk;
  logic [2:0]             state;
  logic [CNT_W-1:0]       cnt;
  logic [IDX_W-1:0]       idx;
  logic [N_DOM-1:0]       rst_q;
  logic [7:0]             loss_q;

  always_ff @(posedge pll_clk_cpu_int or negedge RST_EXT_N) begin
    if (!RST_EXT_N) sync <= '0;
    else            sync <= {sync[SYNC_STAGES-2:0], pll_locked};
  end

  assign lk = sync[SYNC_STAGES-1];

  // sw_rst_req is a one-cycle pulse with no back-pressure: it is acted on only when
  // the sequencer is in RUN with a non-zero mask, otherwise it is silently dropped.
  always_ff @(posedge pll_clk_cpu_int or negedge RST_EXT_N) begin
    if (!RST_EXT_N) begin
      state  <= S_HOLD;
      cnt    <= '0;
      idx    <= '0;
      rst_q  <= '0;
      loss_q <= '0;
    end else if (state != S_HOLD && !lk) begin
      // Lock loss outranks everything, including a same-cycle soft-reset request.
      state  <= S_HOLD;
      cnt    <= '0;
      idx    <= '0;
      rst_q  <= '0;
      if (loss_q != 8'hFF) loss_q <= loss_q + 8'd1;
    end else begin
      case (state)
        S_HOLD: begin
          rst_q <= '0;
          cnt   <= '0;
          if (lk) state <= S_STABLE;
        end
        S_STABLE: begin
          if (cnt == STABLE_LAST) begin
            state <= S_RELEASE;
            cnt   <= '0;
            idx   <= IDX_W'(1);
            rst_q <= N_DOM'(1);
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_RELEASE: begin
          if (idx == IDX_DONE) begin
            state <= S_RUN;
            cnt   <= '0;
          end else if (cnt == GAP_LAST) begin
            rst_q <= rst_q | (N_DOM'(1) << idx);
            idx   <= idx + IDX_W'(1);
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_RUN: begin
          if (sw_rst_req && (|sw_rst_mask)) begin
            state <= S_SWRST;
            cnt   <= '0;
            rst_q <= ~sw_rst_mask;
          end
        end
        S_SWRST: begin
          if (cnt == PULSE_LAST) begin
            state <= S_RUN;
            cnt   <= '0;
            rst_q <= '1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= S_HOLD;
          cnt   <= '0;
          rst_q <= '0;
        end
      endcase
    end
  end

  assign rst_n_out     = rst_q;
  assign all_released  = (state == S_RUN);
  assign seq_state     = state;
  assign lock_loss_cnt = loss_q;

endmodule

// File: tb/tb_hins_rst_seq.sv
// Directed and randomized bench for hins_rst_seq, checked against a phase/elapsed-time
// reference model of the sequencer behaviour.
module tb_hins_rst_seq;

  localparam int N      = 4;
  localparam int STABLE = 16;
  localparam int GAP    = 4;
  localparam int PULSE  = 3;

  localparam int P_HOLD    = 0;
  localparam int P_STABLE  = 1;
  localparam int P_RELEASE = 2;
  localparam int P_RUN     = 3;
  localparam int P_SWRST   = 4;

  logic         clk;
  logic         rst_ext_n;
  logic         pll_locked;
  logic         sw_rst_req;
  logic [N-1:0] sw_rst_mask;
  logic [N-1:0] rst_n_out;
  logic         all_released;
  logic [2:0]   seq_state;
  logic [7:0]   lock_loss_cnt;

  int vectors;
  int miscompares;

  // reference model: phase plus cycles elapsed inside that phase
  int         m_phase;
  int         m_t;
  int         m_loss;
  logic [1:0] m_sync;
  logic [N-1:0] m_mask;

  hins_rst_seq #(
    .N_DOM(N), .SYNC_STAGES(2), .LOCK_STABLE_CYC(STABLE),
    .STAGE_GAP_CYC(GAP), .SW_PULSE_CYC(PULSE), .CNT_W(16)
  ) dut (
    .pll_clk_cpu_int(clk),
    .RST_EXT_N(rst_ext_n),
    .pll_locked(pll_locked),
    .sw_rst_req(sw_rst_req),
    .sw_rst_mask(sw_rst_mask),
    .rst_n_out(rst_n_out),
    .all_released(all_released),
    .seq_state(seq_state),
    .lock_loss_cnt(lock_loss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = P_HOLD;
    m_t     = 0;
    m_loss  = 0;
    m_sync  = 2'b00;
    m_mask  = '0;
  endtask

  task automatic model_step();
    logic lk;
    lk     = m_sync[1];
    m_sync = {m_sync[0], pll_locked};
    if (m_phase != P_HOLD && !lk) begin
      m_phase = P_HOLD;
      m_t     = 0;
      if (m_loss < 255) m_loss++;
    end else begin
      case (m_phase)
        P_HOLD: if (lk) begin m_phase = P_STABLE; m_t = 0; end
        P_STABLE: begin
          m_t++;
          if (m_t == STABLE) begin m_phase = P_RELEASE; m_t = 0; end
        end
        P_RELEASE: begin
          m_t++;
          if (m_t == (N - 1) * GAP + 1) begin m_phase = P_RUN; m_t = 0; end
        end
        P_RUN: if (sw_rst_req && sw_rst_mask != '0) begin
          m_phase = P_SWRST; m_t = 0; m_mask = sw_rst_mask;
        end
        default: begin
          m_t++;
          if (m_t == PULSE) begin m_phase = P_RUN; m_t = 0; end
        end
      endcase
    end
  endtask

  function automatic logic [N-1:0] exp_rst();
    logic [N-1:0] r;
    r = '0;
    case (m_phase)
      P_RELEASE: for (int k = 0; k < N; k++) r[k] = (m_t >= k * GAP);
      P_RUN:     r = '1;
      P_SWRST:   r = ~m_mask;
      default:   r = '0;
    endcase
    return r;
  endfunction

  task automatic check_all();
    check("rst_n_out",     32'(rst_n_out),     32'(exp_rst()));
    check("all_released",  32'(all_released),  32'(m_phase == P_RUN));
    check("seq_state",     32'(seq_state),     32'(m_phase));
    check("lock_loss_cnt", 32'(lock_loss_cnt), 32'(m_loss));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic wait_run(input int budget);
    int n;
    n = 0;
    while (!all_released && n < budget) begin cycle(); n++; end
    check("run_reached", 32'(all_released), 32'd1);
  endtask

  // counts the STABLE dwell once it starts and checks domain 0 releases right after
  task automatic stable_len_check(input string tag);
    int n;
    n = 0;
    while (seq_state != 3'd1 && n < 20) begin cycle(); n++; end
    n = 0;
    while (seq_state == 3'd1 && n < 40) begin cycle(); n++; end
    check({tag, "_stable_len"}, 32'(n), 32'(STABLE));
    check({tag, "_first_rel"}, 32'(rst_n_out), 32'h1);
  endtask

  task automatic async_reset_check(input string tag);
    #1 rst_ext_n = 1'b0;
    #1;
    check({tag, "_rst_n_out"}, 32'(rst_n_out),     32'h0);
    check({tag, "_all_rel"},   32'(all_released),  32'h0);
    check({tag, "_state"},     32'(seq_state),     32'h0);
    check({tag, "_loss"},      32'(lock_loss_cnt), 32'h0);
    model_reset();
    @(negedge clk);
    rst_ext_n = 1'b1;
  endtask

  initial begin
    int seg;
    logic cur;
    vectors     = 0;
    miscompares = 0;
    rst_ext_n   = 1'b0;
    pll_locked  = 1'b0;
    sw_rst_req  = 1'b0;
    sw_rst_mask = '0;
    model_reset();

    // reset state
    repeat (3) @(negedge clk);
    check_all();
    rst_ext_n = 1'b1;
    repeat (3) cycle();

    // T1 power-up with explicit cycle numbers
    pll_locked = 1'b1;
    for (int c = 0; c <= 32; c++) begin
      logic [N-1:0] r;
      cycle();
      for (int k = 0; k < N; k++) r[k] = (c >= STABLE + 2 + k * GAP);
      if (c == 1 || c == 2) check("t1_state", 32'(seq_state), (c == 2) ? 32'd1 : 32'd0);
      check("t1_rst", 32'(rst_n_out), 32'(r));
      check("t1_all", 32'(all_released), 32'(c >= 31));
    end

    // T2 glitchy lock from a fresh start
    async_reset_check("t2_pre");
    repeat (3) cycle();
    repeat (10) cycle();
    pll_locked = 1'b0;
    cycle();
    pll_locked = 1'b1;
    repeat (2) cycle();
    check("t2_hold", 32'(seq_state), 32'd0);
    check("t2_loss", 32'(lock_loss_cnt), 32'd1);
    check("t2_rst", 32'(rst_n_out), 32'h0);
    stable_len_check("t2");
    wait_run(40);

    // T3 soft reset of domains 1 and 2
    sw_rst_req = 1'b1; sw_rst_mask = 4'b0110;
    cycle();
    sw_rst_req = 1'b0; sw_rst_mask = '0;
    check("t3_rst_0", 32'(rst_n_out), 32'b1001);
    check("t3_all_0", 32'(all_released), 32'd0);
    repeat (2) cycle();
    check("t3_rst_2", 32'(rst_n_out), 32'b1001);
    cycle();
    check("t3_rst_end", 32'(rst_n_out), 32'b1111);
    check("t3_all_end", 32'(all_released), 32'd1);

    // ignored requests: mask zero in RUN
    sw_rst_req = 1'b1; sw_rst_mask = '0;
    cycle();
    sw_rst_req = 1'b0;
    check("mask0_ignored", 32'(seq_state), 32'd3);

    // T4 lock loss collides with soft-reset request
    pll_locked = 1'b0;
    repeat (2) cycle();
    sw_rst_req = 1'b1; sw_rst_mask = 4'b1111;
    cycle();
    sw_rst_req = 1'b0; sw_rst_mask = '0;
    check("t4_state", 32'(seq_state), 32'd0);
    check("t4_rst", 32'(rst_n_out), 32'h0);
    check("t4_loss", 32'(lock_loss_cnt), 32'd2);

    // T5 abort after domain 1 released
    pll_locked = 1'b1;
    seg = 0;
    while (rst_n_out != 4'b0011 && seg < 60) begin cycle(); seg++; end
    check("t5_reached", 32'(rst_n_out), 32'b0011);
    pll_locked = 1'b0;
    repeat (3) cycle();
    check("t5_state", 32'(seq_state), 32'd0);
    check("t5_rst", 32'(rst_n_out), 32'h0);
    pll_locked = 1'b1;
    stable_len_check("t5");
    wait_run(40);

    // randomized lock bursts and soft-reset requests
    cur = 1'b1;
    seg = 0;
    for (int i = 0; i < 1500; i++) begin
      if (seg == 0) begin
        cur = ~cur;
        seg = cur ? int'($urandom_range(5, 80)) : int'($urandom_range(1, 4));
      end
      seg--;
      pll_locked  = cur;
      sw_rst_req  = ($urandom_range(0, 7) == 0);
      sw_rst_mask = 4'($urandom_range(0, 15));
      cycle();
    end
    sw_rst_req = 1'b0; sw_rst_mask = '0;

    // T6 saturation of the lock-loss counter
    for (int i = 0; i < 300; i++) begin
      pll_locked = 1'b1;
      repeat (3) cycle();
      pll_locked = 1'b0;
      repeat (3) cycle();
    end
    check("t6_sat", 32'(lock_loss_cnt), 32'd255);
    pll_locked = 1'b1;
    wait_run(60);
    check("t6_sat_run", 32'(lock_loss_cnt), 32'd255);
    async_reset_check("t6_async");
    repeat (4) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
